store_credit_tracker: RTL and testbench
=======================================

STORE_CREDIT_TRACKER -- requirements
Module: store_credit_tracker

Interface
REQ-001 Parameter MaxOutstandingStores, default 7, is the maximum number of granted-but-unacknowledged stores (range 1..255).
REQ-002 Parameter TimeoutCycles, default 1024, is the watchdog threshold in cycles; it is used only with the configuration macro (REQ-026).
REQ-003 Derived localparam CntWidth = $clog2(MaxOutstandingStores+1).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, synchronous and active-low.
REQ-006 st_req_i  input  1  LSU requests issue of one store this cycle.
REQ-007 st_gnt_o  output  1  store issue granted this cycle (combinational).
REQ-008 st_ack_i  input  1  memory side reports completion of one outstanding store.
REQ-009 fence_req_i  input  1  request to drain all outstanding stores (fence / AMO ordering).
REQ-010 fence_done_o  output  1  one-cycle pulse: drain complete.
REQ-011 outstanding_o  output  CntWidth  current outstanding count (registered).
REQ-012 full_o / empty_o  output  1 each  count==MaxOutstandingStores / count==0 (registered).
REQ-013 underflow_o  output  1  sticky error: ack received while count==0.
REQ-014 timeout_o  output  1  sticky watchdog error (REQ-026).

Function
REQ-015 FSM states are IDLE (count==0), BUSY (count>0), DRAIN (fence pending, issue blocked), and DONE (fence_done_o high).
REQ-016 st_gnt_o = st_req_i && !full_o && state in {IDLE, BUSY}; it does not depend on st_ack_i in the same cycle, so there is no ack->gnt combinational path.
REQ-017 Count update: +1 on grant only, -1 on ack only (count>0), unchanged on grant and ack in the same cycle.
REQ-018 Ack with count==0: count stays 0, underflow_o is set the next cycle and holds until reset, and no other state change occurs.
REQ-019 IDLE/BUSY transitions: IDLE->BUSY when the count becomes nonzero, BUSY->IDLE when the count becomes zero, both evaluated on the next-count value.
REQ-020 fence_req_i high in IDLE or BUSY: go to DRAIN next cycle; fence_req_i is ignored in DRAIN and DONE.
REQ-021 In DRAIN, acks continue to decrement the count; when the registered count==0, go to DONE next cycle.
REQ-022 DONE: fence_done_o=1 for exactly one cycle, then go to IDLE; grants resume the cycle after DONE.
REQ-023 Fence with empty tracker: fence_req_i at cycle N, DRAIN at N+1, fence_done_o at N+2, IDLE at N+3 (minimum latency 2).
REQ-024 full_o blocks grants; overflow is therefore unreachable, and the count never exceeds MaxOutstandingStores nor wraps.

Reset
REQ-025 While rst_ni==0 at a clock edge: state=IDLE, count=0, full_o=0, empty_o=1, fence_done_o=0, underflow_o=0, timeout_o=0, watchdog counter=0; st_gnt_o=0 during reset, and any fence in progress is abandoned without a done pulse.

Configuration
REQ-026 With STORE_CREDIT_WATCHDOG_EN defined: a watchdog counter increments each cycle while count>0 with no ack and clears on any ack or when count==0; on reaching TimeoutCycles, timeout_o is set sticky until reset.
REQ-027 Without STORE_CREDIT_WATCHDOG_EN: no watchdog counter is instantiated, timeout_o is tied to 0, and the TimeoutCycles parameter is unused.

Verification
REQ-028 8 back-to-back st_req_i with no acks -> first 7 granted, outstanding_o=7, full_o=1, 8th st_gnt_o=0.
REQ-029 Count=7 (full), st_req_i and st_ack_i in the same cycle -> st_gnt_o=0, count=6 next cycle; the following st_req_i is granted.
REQ-030 Count=3, fence_req_i pulse, st_req_i held high, 3 acks at cycles +2, +4, +6 -> no grants, fence_done_o single pulse at +8, grant at +9.
REQ-031 Reset, then st_ack_i for 1 cycle -> underflow_o=1 next cycle and still 1 after 100 cycles, count=0.
REQ-032 With macro and TimeoutCycles=16, 1 grant then no ack -> timeout_o=1 exactly 16 cycles after the count became 1; without macro, timeout_o=0 throughout.
REQ-033 Count=4 in DRAIN, rst_ni=0 for 1 cycle -> IDLE, count=0, no fence_done_o pulse, grants available the cycle after reset deasserts.

Source files
------------

// File: rtl/store_credit_tracker.sv
// Store credit tracker: bounds granted-but-unacknowledged stores and drains them on fence.
// Optional watchdog on stalled acks is enabled by defining STORE_CREDIT_WATCHDOG_EN.
module store_credit_tracker #(
  parameter int MaxOutstandingStores = 7,
  parameter int TimeoutCycles        = 1024,
  localparam int CntWidth            = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                st_req_i,
  output logic                st_gnt_o,
  input  logic                st_ack_i,
  input  logic                fence_req_i,
  output logic                fence_done_o,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                underflow_o,
  output logic                timeout_o
);

  // state | meaning
  // IDLE  | no stores outstanding, issue allowed
  // BUSY  | one or more stores outstanding, issue allowed
  // DRAIN | fence pending, issue blocked until count reaches zero
  // DONE  | drain complete, fence_done_o high for this one cycle
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstandingStores);
  localparam logic [CntWidth-1:0] CntZero = '0;
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                full_q, empty_q, underflow_q;
  logic                issue_state;
  logic                gnt;

  // Grant depends only on registered state and the request, never on the ack.
  assign issue_state = (state_q == IDLE) || (state_q == BUSY);
  assign gnt         = rst_ni && st_req_i && !full_q && issue_state;

  always_comb begin
    count_d = count_q;
    if (gnt && !st_ack_i) begin
      count_d = count_q + CntOne;
    end else if (!gnt && st_ack_i && (count_q != CntZero)) begin
      count_d = count_q - CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, BUSY: begin
        if (fence_req_i)              state_d = DRAIN;
        else if (count_d != CntZero)  state_d = BUSY;
        else                          state_d = IDLE;
      end
      DRAIN:   if (count_q == CntZero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      count_q     <= CntZero;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= (count_d == CntMax);
      empty_q <= (count_d == CntZero);
      if (st_ack_i && (count_q == CntZero)) underflow_q <= 1'b1;
    end
  end

`ifdef STORE_CREDIT_WATCHDOG_EN
  localparam int WdWidth = $clog2(TimeoutCycles + 1);
  localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TimeoutCycles);
  localparam logic [WdWidth-1:0] WdLast  = WdWidth'(TimeoutCycles - 1);

  logic [WdWidth-1:0] wd_q;
  logic               timeout_q;
  logic               wd_run;

  assign wd_run = !st_ack_i && (count_q != CntZero);

  // Timeout asserts on the same edge the counter reaches the limit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!wd_run)              wd_q <= '0;
      else if (wd_q != WdLimit) wd_q <= wd_q + WdWidth'(1);
      if (wd_run && (wd_q == WdLast)) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign st_gnt_o      = gnt;
  assign fence_done_o  = (state_q == DONE);
  assign outstanding_o = count_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_store_credit_tracker.sv
// Scoreboard bench for store_credit_tracker: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares those due in the current cycle.
module tb_store_credit_tracker;

  localparam int Max = 7;
  localparam int Tmo = 16;
  localparam int CW  = $clog2(Max + 1);

  localparam int S_GNT = 0, S_OUT = 1, S_FULL = 2, S_EMPTY = 3,
                 S_DONE = 4, S_UFL = 5, S_TMO = 6;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          st_req = 1'b0, st_ack = 1'b0, fence_req = 1'b0;
  logic          st_gnt, fence_done, full, empty, underflow, timeout;
  logic [CW-1:0] outstanding;

  store_credit_tracker #(.MaxOutstandingStores(Max), .TimeoutCycles(Tmo)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .st_req_i(st_req), .st_gnt_o(st_gnt),
    .st_ack_i(st_ack), .fence_req_i(fence_req), .fence_done_o(fence_done),
    .outstanding_o(outstanding), .full_o(full), .empty_o(empty),
    .underflow_o(underflow), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int sig; int val; string tag; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(int sig);
    case (sig)
      S_GNT:   return int'(st_gnt);
      S_OUT:   return int'(outstanding);
      S_FULL:  return int'(full);
      S_EMPTY: return int'(empty);
      S_DONE:  return int'(fence_done);
      S_UFL:   return int'(underflow);
      default: return int'(timeout);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].sig);
        n_cmp++;
        if (act != sb[i].val) begin
          n_bad++;
          $display("FAIL %s (cycle %0d): got %0d, expected %0d", sb[i].tag, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string tag, input int sig, input int val);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values, with a request held during reset
    st_req = 1'b1;
    step();
    expect_now("rst_gnt", S_GNT, 0);
    expect_now("rst_out", S_OUT, 0);
    expect_now("rst_full", S_FULL, 0);
    expect_now("rst_empty", S_EMPTY, 1);
    expect_now("rst_done", S_DONE, 0);
    expect_now("rst_ufl", S_UFL, 0);
    expect_now("rst_tmo", S_TMO, 0);
    step();
    rst_ni = 1'b1; st_req = 1'b0;

    // Eight back-to-back requests: seven granted, then full
    for (int i = 0; i < 8; i++) begin
      step();
      st_req = 1'b1;
      expect_now("fill_gnt", S_GNT, (i < 7) ? 1 : 0);
    end
    step();
    st_req = 1'b0;
    expect_now("fill_out", S_OUT, 7);
    expect_now("fill_full", S_FULL, 1);
    expect_now("fill_empty", S_EMPTY, 0);

    // Full with request and ack together: no grant, count drops to six
    st_req = 1'b1; st_ack = 1'b1;
    expect_now("full_ack_gnt", S_GNT, 0);
    step();
    st_ack = 1'b0;
    expect_now("full_ack_out", S_OUT, 6);
    expect_now("full_ack_full", S_FULL, 0);
    expect_now("after_full_gnt", S_GNT, 1);
    step();
    st_req = 1'b0;
    expect_now("refill_out", S_OUT, 7);
    expect_now("refill_full", S_FULL, 1);

    for (int i = 0; i < 4; i++) begin
      step();
      st_ack = 1'b1;
    end
    step();
    st_ack = 1'b0;
    expect_now("pre_fence_out", S_OUT, 3);

    // Fence at count 3: acks at +2,+4,+6, done at +8, grant at +9
    fence_req = 1'b1;
    expect_now("fence0_done", S_DONE, 0);
    for (int k = 1; k <= 9; k++) begin
      step();
      fence_req = 1'b0;
      st_req = 1'b1;
      st_ack = (k == 2 || k == 4 || k == 6);
      expect_now("drain_gnt", S_GNT, (k == 9) ? 1 : 0);
      expect_now("drain_done", S_DONE, (k == 8) ? 1 : 0);
      if (k == 7) expect_now("drain_out", S_OUT, 0);
    end
    step();
    st_req = 1'b0; st_ack = 1'b1;
    expect_now("post_fence_out", S_OUT, 1);
    step();
    st_ack = 1'b0;
    expect_now("post_fence_empty", S_EMPTY, 1);

    // Fence on an empty tracker: done two cycles later, grant one after that
    fence_req = 1'b1;
    expect_now("efence_n_done", S_DONE, 0);
    step();
    fence_req = 1'b0;
    expect_now("efence_n1_done", S_DONE, 0);
    step();
    st_req = 1'b1;
    expect_now("efence_n2_done", S_DONE, 1);
    expect_now("efence_n2_gnt", S_GNT, 0);
    step();
    expect_now("efence_n3_done", S_DONE, 0);
    expect_now("efence_n3_gnt", S_GNT, 1);
    step();
    st_req = 1'b0; st_ack = 1'b1;
    step();
    st_ack = 1'b0;
    expect_now("efence_out", S_OUT, 0);

    // Reset in the middle of a drain
    for (int i = 0; i < 4; i++) begin
      step();
      st_req = 1'b1;
    end
    step();
    st_req = 1'b0; fence_req = 1'b1;
    expect_now("rdrain_out", S_OUT, 4);
    step();
    fence_req = 1'b0; st_req = 1'b1;
    expect_now("rdrain_gnt", S_GNT, 0);
    step();
    rst_ni = 1'b0;
    expect_now("rdrain_rst_gnt", S_GNT, 0);
    step();
    rst_ni = 1'b1;
    expect_now("rdrain_out0", S_OUT, 0);
    expect_now("rdrain_empty", S_EMPTY, 1);
    expect_now("rdrain_done", S_DONE, 0);
    expect_now("rdrain_gnt_back", S_GNT, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      st_req = 1'b0;
      expect_now("rdrain_nodone", S_DONE, 0);
    end
    expect_now("rdrain_out1", S_OUT, 1);
    st_ack = 1'b1;
    step();
    st_ack = 1'b0;

    // One grant with no ack: watchdog fires sixteen cycles after count becomes 1
    st_req = 1'b1;
    step();
    st_req = 1'b0;
    expect_now("wd_out", S_OUT, 1);
    for (int k = 1; k <= 20; k++) begin
      step();
`ifdef STORE_CREDIT_WATCHDOG_EN
      expect_now("wd_tmo", S_TMO, (k >= 16) ? 1 : 0);
`else
      expect_now("wd_tmo", S_TMO, 0);
`endif
    end
    st_ack = 1'b1;
    step();
    st_ack = 1'b0;

    // Underflow after reset is sticky
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    expect_now("ufl_tmo_cleared", S_TMO, 0);
    step();
    st_ack = 1'b1;
    expect_now("ufl_before", S_UFL, 0);
    step();
    st_ack = 1'b0;
    expect_now("ufl_set", S_UFL, 1);
    expect_now("ufl_out", S_OUT, 0);
    repeat (100) step();
    expect_now("ufl_hold", S_UFL, 1);
    expect_now("ufl_hold_out", S_OUT, 0);
    expect_now("ufl_hold_empty", S_EMPTY, 1);

    step();
    step();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, expected 0", sb.size());
      n_bad = n_bad + sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
